// File: rtl/mem_port_arbiter_if.sv
// Request/grant and memory bus bundle for the three-requester memory arbiter.
// The "master" side is everything around the arbiter: loader, fetch, data port and RAM.
// The "slave" side is the arbiter itself.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  // boot loader (write-only)
  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_wdata;
  logic              ld_done;
  logic              ld_gnt;
  // instruction fetch (read-only)
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;
  // core data access
  logic              d_req;
  logic              d_we;
  logic [3:0]        d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  // single-port RAM
  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    output ld_req, ld_addr, ld_wdata, ld_done,
    input  ld_gnt,
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_be, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  ld_req, ld_addr, ld_wdata, ld_done,
    output ld_gnt,
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between a boot loader, instruction
// fetch and core data access. BOOT lets only the loader write while the core
// is held; RUN gives data priority over fetch with a fetch starvation guard.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic boot_en,
  output logic core_hold,
  mem_port_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] starve_cnt_reg, starve_cnt_next;
  logic             if_rvalid_reg, d_rvalid_reg;
  logic             fetch_wins;

  // State, starvation counter and read-valid pipeline registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= boot_en ? BOOT : RUN;
      starve_cnt_reg <= '0;
      if_rvalid_reg  <= 1'b0;
      d_rvalid_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
      if_rvalid_reg  <= bus.if_gnt;
      d_rvalid_reg   <= bus.d_gnt & ~bus.d_we;
    end
  end

  // Next state, grants and RAM bus steering from the current requests
  always_comb begin
    state_next    = state_reg;
    core_hold     = 1'b1;
    bus.ld_gnt    = 1'b0;
    bus.if_gnt    = 1'b0;
    bus.d_gnt     = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_be    = 4'b0000;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    // fetch takes the slot when alone, or when it has been denied long enough
    fetch_wins    = bus.if_req && (!bus.d_req || starve_cnt_reg == LIMIT);

    if (!reset) begin
      case (state_reg)
        BOOT: begin
          // the loader write in the ld_done cycle is still honoured
          if (bus.ld_req) begin
            bus.ld_gnt    = 1'b1;
            bus.mem_en    = 1'b1;
            bus.mem_we    = 1'b1;
            bus.mem_be    = 4'b1111;
            bus.mem_addr  = bus.ld_addr;
            bus.mem_wdata = bus.ld_wdata;
          end
          if (bus.ld_done) begin
            state_next = RUN;
          end
        end
        RUN: begin
          core_hold = 1'b0;
          if (fetch_wins) begin
            bus.if_gnt   = 1'b1;
            bus.mem_en   = 1'b1;
            bus.mem_be   = 4'b1111;
            bus.mem_addr = bus.if_addr;
          end else if (bus.d_req) begin
            bus.d_gnt     = 1'b1;
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.d_we;
            bus.mem_be    = bus.d_we ? bus.d_be : 4'b1111;
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  // Starvation counter: counts denied fetch cycles, saturating at the limit
  always_comb begin
    starve_cnt_next = '0;
    if (bus.if_req && !bus.if_gnt) begin
      starve_cnt_next = (starve_cnt_reg == LIMIT) ? LIMIT : starve_cnt_reg + 1'b1;
    end
  end

  // Read return: fixed one-cycle latency, rvalid dropped immediately by reset
  always_comb begin
    bus.if_rvalid = if_rvalid_reg & ~reset;
    bus.d_rvalid  = d_rvalid_reg & ~reset;
    bus.if_rdata  = bus.mem_rdata;
    bus.d_rdata   = bus.mem_rdata;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed test-plan steps followed
// by randomized traffic, all compared against a cycle-level reference model.
module tb_mem_port_arbiter;

  localparam int ADDR_W       = 32;
  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic reset;
  logic boot_en;
  logic core_hold;
  int   checks = 0;
  int   failures = 0;

  // reference model state
  bit   m_boot;
  int   m_starve;
  bit   m_prev_if;
  bit   m_prev_dload;
  logic last_if_gnt;
  logic last_d_gnt;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk       (clk),
    .reset     (reset),
    .boot_en   (boot_en),
    .core_hold (core_hold),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.ld_req = 0; bus.ld_addr = '0; bus.ld_wdata = '0; bus.ld_done = 0;
    bus.if_req = 0; bus.if_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_be = '0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_rdata = $urandom;
  endtask

  // Called at posedge+1 with inputs set; checks outputs, then advances one clock.
  task automatic run_cycle(input string tag);
    logic e_ld, e_if, e_d, e_hold, e_en, e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wdata;
    logic e_irv, e_drv;
    #3;
    e_ld = 0; e_if = 0; e_d = 0; e_hold = 1; e_en = 0; e_we = 0;
    e_be = 4'b0000; e_addr = '0; e_wdata = '0;
    if (!reset) begin
      if (m_boot) begin
        e_ld = bus.ld_req;
        if (e_ld) begin
          e_en = 1; e_we = 1; e_be = 4'b1111; e_addr = bus.ld_addr; e_wdata = bus.ld_wdata;
        end
      end else begin
        e_hold = 0;
        if (bus.if_req && (!bus.d_req || m_starve == STARVE_LIMIT)) e_if = 1;
        else if (bus.d_req) e_d = 1;
        if (e_if) begin
          e_en = 1; e_be = 4'b1111; e_addr = bus.if_addr;
        end else if (e_d) begin
          e_en = 1; e_we = bus.d_we; e_be = bus.d_we ? bus.d_be : 4'b1111;
          e_addr = bus.d_addr; e_wdata = bus.d_wdata;
        end
      end
    end
    e_irv = m_prev_if & ~reset;
    e_drv = m_prev_dload & ~reset;
    check({tag, ".ld_gnt"}, bus.ld_gnt, e_ld);
    check({tag, ".if_gnt"}, bus.if_gnt, e_if);
    check({tag, ".d_gnt"}, bus.d_gnt, e_d);
    check({tag, ".core_hold"}, core_hold, e_hold);
    check({tag, ".mem_en"}, bus.mem_en, e_en);
    check({tag, ".mem_we"}, bus.mem_we, e_we);
    check({tag, ".mem_be"}, bus.mem_be, e_be);
    if (e_en) check({tag, ".mem_addr"}, bus.mem_addr, e_addr);
    if (e_en && e_we) check({tag, ".mem_wdata"}, bus.mem_wdata, e_wdata);
    check({tag, ".if_rvalid"}, bus.if_rvalid, e_irv);
    check({tag, ".d_rvalid"}, bus.d_rvalid, e_drv);
    if (e_irv) check({tag, ".if_rdata"}, bus.if_rdata, bus.mem_rdata);
    if (e_drv) check({tag, ".d_rdata"}, bus.d_rdata, bus.mem_rdata);
    last_if_gnt = bus.if_gnt;
    last_d_gnt  = bus.d_gnt;
    $display("cycle %s: rst=%0b ld=%0b if=%0b d=%0b hold=%0b en=%0b we=%0b be=%0h addr=%0h irv=%0b drv=%0b",
             tag, reset, bus.ld_gnt, bus.if_gnt, bus.d_gnt, core_hold, bus.mem_en,
             bus.mem_we, bus.mem_be, bus.mem_addr, bus.if_rvalid, bus.d_rvalid);
    @(posedge clk);
    if (reset) begin
      m_boot = boot_en; m_starve = 0; m_prev_if = 0; m_prev_dload = 0;
    end else begin
      m_prev_if    = e_if;
      m_prev_dload = e_d & ~bus.d_we;
      if (bus.if_req && !e_if) m_starve = (m_starve < STARVE_LIMIT) ? m_starve + 1 : STARVE_LIMIT;
      else m_starve = 0;
      if (m_boot && bus.ld_done) m_boot = 0;
    end
    #1;
  endtask

  initial begin
    reset = 1; boot_en = 1; idle();
    m_boot = 1; m_starve = 0; m_prev_if = 0; m_prev_dload = 0;
    @(posedge clk); #1;

    // Boot load: reset with boot_en=1, loader write while fetch is refused
    bus.if_req = 1; bus.if_addr = 32'h4;
    run_cycle("boot_reset");
    reset = 0;
    bus.ld_req = 1; bus.ld_addr = 32'h0; bus.ld_wdata = 32'h0000_0013;
    run_cycle("boot_write");
    check("boot_write_gnt", last_if_gnt, 1'b0);
    bus.ld_addr = 32'h4; bus.ld_wdata = 32'h0000_0067; bus.ld_done = 1;
    run_cycle("boot_done");
    idle();
    run_cycle("boot_to_run");
    check("core_released", core_hold, 1'b0);

    // Fetch only in RUN after reset with boot_en=0
    reset = 1; boot_en = 0;
    run_cycle("run_reset");
    reset = 0;
    bus.if_req = 1; bus.if_addr = 32'h10;
    run_cycle("fetch_req");
    idle(); bus.mem_rdata = 32'hDEAD_BEEF;
    run_cycle("fetch_ret");

    // Contention: data load beats fetch
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h100; bus.if_req = 1; bus.if_addr = 32'h20;
    run_cycle("contend");
    idle(); bus.mem_rdata = 32'h1234_5678;
    run_cycle("contend_ret");

    // Starvation: both held, fetch wins every fifth cycle
    for (int i = 0; i < 10; i++) begin
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h300 + i; bus.if_req = 1; bus.if_addr = 32'h40 + i;
      bus.mem_rdata = $urandom;
      run_cycle($sformatf("starve%0d", i));
      check($sformatf("starve_pattern%0d", i), last_if_gnt, (i % 5) == 4);
    end
    idle();
    run_cycle("starve_end");

    // Byte store: no read data comes back
    bus.d_req = 1; bus.d_we = 1; bus.d_be = 4'b0010; bus.d_addr = 32'h200; bus.d_wdata = 32'h0000_AB00;
    run_cycle("store");
    idle();
    run_cycle("store_ret");

    // Reset mid-read: reset arrives in the cycle after a fetch grant
    bus.if_req = 1; bus.if_addr = 32'h80;
    run_cycle("midread_req");
    idle(); reset = 1; boot_en = 1;
    run_cycle("midread_rst");
    check("midread_if_rvalid", bus.if_rvalid, 1'b0);
    reset = 0;
    run_cycle("midread_boot");
    check("midread_hold", core_hold, 1'b1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      reset   = ($urandom_range(0, 39) == 0);
      boot_en = $urandom_range(0, 1);
      bus.ld_req   = $urandom_range(0, 1);
      bus.ld_addr  = $urandom;
      bus.ld_wdata = $urandom;
      bus.ld_done  = ($urandom_range(0, 7) == 0);
      bus.if_req   = ($urandom_range(0, 3) != 0);
      bus.if_addr  = $urandom;
      bus.d_req    = ($urandom_range(0, 3) != 0);
      bus.d_we     = $urandom_range(0, 1);
      bus.d_be     = 4'($urandom);
      bus.d_addr   = $urandom;
      bus.d_wdata  = $urandom;
      bus.mem_rdata = $urandom;
      run_cycle($sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM between three requesters: instruction fetch, core data access, and a boot loader.
- Sits between the pipelined core's fetch and data ports and the unified memory.
- Sequences a BOOT phase, in which only the loader may write and the core is held, then a RUN phase with data-over-fetch priority and a fetch starvation guard.

Parameters:
- ADDR_W, 32, width of all address buses
- STARVE_LIMIT, 4, number of consecutive denied fetch cycles before fetch is forced to win; legal range is 1 or more

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- boot_en  in  1  sampled during reset; 1 selects BOOT as the first state after reset, 0 selects RUN
- core_hold  out  1  holds the core in reset; 1 during reset and while in BOOT
- ld_req  in  1  loader write request
- ld_addr  in  ADDR_W  loader word address
- ld_wdata  in  32  loader write data
- ld_done  in  1  one-cycle pulse: boot image complete
- ld_gnt  out  1  loader request accepted this cycle
- if_req  in  1  fetch read request
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  32  fetch read data
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_be  in  4  store byte enables
- d_addr  in  ADDR_W  data address
- d_wdata  in  32  store data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid
- d_rdata  out  32  load data
- mem_en  out  1  RAM access enable
- mem_we  out  1  RAM write enable
- mem_be  out  4  RAM byte enables
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data; valid the cycle after a read is issued

Behaviour:
- FSM states are BOOT and RUN.
- During reset the next state is BOOT if boot_en=1, otherwise RUN.
- Reset clears: starvation counter, if_rvalid, d_rvalid. While reset is high: all grants are 0, mem_en=0, core_hold=1.
- Grant and mem_* outputs are combinational from the current requests and state. The winner's address, data and enables drive mem_*.
- When no request is granted: mem_en=0, mem_we=0, mem_be=0.

BOOT state:
- ld_gnt=ld_req. A granted loader access drives mem_we=1 and mem_be=1111; the loader is write-only.
- if_gnt=0 and d_gnt=0 regardless of requests. core_hold=1.
- ld_done=1 moves the FSM to RUN on the next cycle. A loader write in the same cycle as ld_done is still granted.
- In RUN, ld_done is ignored.

RUN state:
- ld_gnt=0 always. core_hold=0.
- Only d_req: d_gnt=1. Only if_req: if_gnt=1.
- Both d_req and if_req: d wins unless the starvation counter equals STARVE_LIMIT, in which case fetch wins.
- Starvation counter:
  - increments in any cycle with if_req=1 and if_gnt=0;
  - clears when if_gnt=1 or if_req=0;
  - saturates at STARVE_LIMIT; width is clog2(STARVE_LIMIT+1).
- Store grant: mem_we=1, mem_be=d_be. Load grant: mem_we=0, mem_be=1111. Fetch grant: mem_we=0, mem_be=1111.

Read return:
- Latency is fixed at 1 cycle.
- if_rvalid is registered from if_gnt. d_rvalid is registered from d_gnt & ~d_we.
- if_rdata and d_rdata both equal mem_rdata; consumers qualify with the rvalid signals.
- Stores never raise d_rvalid.
- A requester not granted holds its request; there is no queueing inside the block.

Reset during operation:
- Reset asserted the cycle after a read grant means the matching rvalid is 0 on the following cycle.
- The FSM restarts in BOOT or RUN according to boot_en.

Test Plan:
- Boot load: reset with boot_en=1, then ld_req with ld_addr=0x0, ld_wdata=0x00000013 -> ld_gnt=1, mem_we=1, mem_be=1111, mem_addr=0x0. An if_req in the same cycle gets if_gnt=0. Pulse ld_done -> core_hold=0 on the next cycle.
- Fetch only (RUN, boot_en=0): if_req with if_addr=0x10, mem_rdata=0xDEADBEEF on the next cycle -> if_gnt=1 and mem_addr=0x10 in the request cycle; next cycle if_rvalid=1, if_rdata=0xDEADBEEF, d_rvalid=0.
- Contention: d_req load at 0x100 and if_req at 0x20 in the same cycle -> d_gnt=1, if_gnt=0, mem_addr=0x100; next cycle d_rvalid=1, if_rvalid=0.
- Starvation (STARVE_LIMIT=4): both requests held high continuously -> d wins 4 consecutive cycles, fetch wins the 5th; the pattern repeats with period 5.
- Byte store: d_req with d_we=1, d_be=0010, d_addr=0x200, d_wdata=0x0000AB00 -> mem_we=1, mem_be=0010, mem_wdata=0x0000AB00; d_rvalid=0 on the next cycle.
- Reset mid-read: reset asserted in the cycle after a fetch grant -> if_rvalid=0; with boot_en=1 the next state is BOOT and core_hold=1.
